// File: rtl/imuldiv_mul_pkg.sv
// Shared types and sizing helpers for the imuldiv iterative multiplier.
package imuldiv_mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CAL  = 2'd1,
    ST_SIGN = 2'd2,
    ST_DONE = 2'd3
  } mul_state_e;

  // Counter must hold W/K itself, hence the +1.
  function automatic int cnt_width(input int w, input int k);
    return $clog2(w / k + 1);
  endfunction

endpackage

// File: rtl/imuldiv_int_mul_param_dpath.sv
// Datapath for the iterative multiplier: operand magnitudes, radix-2^K
// shift-add accumulator, step counter and final sign fix-up.
module imuldiv_int_mul_param_dpath
  import imuldiv_mul_pkg::*;
#(
  parameter int W = 32,
  parameter int K = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic           step,
  input  logic           negate,
  input  logic [W-1:0]   a_in,
  input  logic [W-1:0]   b_in,
  input  logic           signed_in,
  output logic [2*W-1:0] acc,
  output logic           b_zero_next,
  output logic           cnt_last
);

  localparam int CW = cnt_width(W, K);

  logic [2*W-1:0] a_reg;
  logic [2*W-1:0] acc_reg;
  logic [W-1:0]   b_reg;
  logic [CW-1:0]  cnt;
  logic           sign_reg;

  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic [W-1:0]   b_shift;
  logic [2*W-1:0] pp;

  // The most-negative operand negates to 2^(W-1), which still fits W unsigned bits.
  assign a_mag = (signed_in && a_in[W-1]) ? (~a_in + W'(1)) : a_in;
  assign b_mag = (signed_in && b_in[W-1]) ? (~b_in + W'(1)) : b_in;

  assign b_shift     = b_reg >> K;
  assign b_zero_next = (b_shift == '0);
  assign cnt_last    = (cnt == CW'(1));
  assign acc         = acc_reg;

  always_comb begin
    pp = '0;
    for (int i = 0; i < K; i++) begin
      if (b_reg[i]) pp = pp + (a_reg << i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg    <= '0;
      b_reg    <= '0;
      acc_reg  <= '0;
      cnt      <= '0;
      sign_reg <= 1'b0;
    end else if (load) begin
      a_reg    <= {{W{1'b0}}, a_mag};
      b_reg    <= b_mag;
      acc_reg  <= '0;
      cnt      <= CW'(W / K);
      sign_reg <= signed_in & (a_in[W-1] ^ b_in[W-1]);
    end else if (step) begin
      acc_reg <= acc_reg + pp;
      a_reg   <= a_reg << K;
      b_reg   <= b_shift;
      cnt     <= cnt - CW'(1);
    end else if (negate && sign_reg) begin
      acc_reg <= ~acc_reg + (2*W)'(1);
    end
  end

endmodule

// File: rtl/imuldiv_int_mul_param.sv
// Iterative K-bits-per-cycle integer multiplier with val/rdy request and
// response channels and optional early termination on a zero multiplier.
module imuldiv_int_mul_param
  import imuldiv_mul_pkg::*;
#(
  parameter int W          = 32,
  parameter int K          = 2,
  parameter int EARLY_TERM = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [W-1:0]   mulreq_msg_a,
  input  logic [W-1:0]   mulreq_msg_b,
  input  logic           mulreq_msg_signed,
  input  logic           mulreq_val,
  output logic           mulreq_rdy,
  output logic [2*W-1:0] mulresp_msg_result,
  output logic           mulresp_val,
  input  logic           mulresp_rdy,
  output mul_state_e     dbg_state
);

  // Handshake: a transfer happens on a rising edge where val and rdy are both
  // high; rdy/val are pure state decodes, the response is held while rdy is low.

  mul_state_e state_q, state_d;
  logic       load, step, negate;
  logic       b_zero_next, cnt_last;
  logic       early_stop;

  assign early_stop = (EARLY_TERM != 0) && b_zero_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    negate  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mulreq_val) begin
          load    = 1'b1;
          state_d = ST_CAL;
        end
      end
      ST_CAL: begin
        step = 1'b1;
        if (cnt_last || early_stop) state_d = ST_SIGN;
      end
      ST_SIGN: begin
        negate  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (mulresp_rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mulreq_rdy  = (state_q == ST_IDLE);
  assign mulresp_val = (state_q == ST_DONE);
  assign dbg_state   = state_q;

  imuldiv_int_mul_param_dpath #(.W(W), .K(K)) u_dpath (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .step        (step),
    .negate      (negate),
    .a_in        (mulreq_msg_a),
    .b_in        (mulreq_msg_b),
    .signed_in   (mulreq_msg_signed),
    .acc         (mulresp_msg_result),
    .b_zero_next (b_zero_next),
    .cnt_last    (cnt_last)
  );

endmodule

// File: tb/tb_imuldiv_int_mul_param.sv
// Bench for imuldiv_int_mul_param: one independent DUT per (W, K, EARLY_TERM)
// configuration, each driven with directed and random products against a model.
module tb_imuldiv_int_mul_param;
  import imuldiv_mul_pkg::*;

  localparam int NCFG = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int GW = (g < 6) ? 8 : 32;
    localparam int GK = (g % 3 == 0) ? 1 : ((g % 3 == 1) ? 2 : 4);
    localparam int GE = (g / 3) % 2;

    logic            reset;
    logic [GW-1:0]   a, b;
    logic            sgn, req_val, req_rdy, resp_val, resp_rdy;
    logic [2*GW-1:0] result;
    mul_state_e      dbg;

    imuldiv_int_mul_param #(.W(GW), .K(GK), .EARLY_TERM(GE)) u_dut (
      .clk                (clk),
      .reset              (reset),
      .mulreq_msg_a       (a),
      .mulreq_msg_b       (b),
      .mulreq_msg_signed  (sgn),
      .mulreq_val         (req_val),
      .mulreq_rdy         (req_rdy),
      .mulresp_msg_result (result),
      .mulresp_val        (resp_val),
      .mulresp_rdy        (resp_rdy),
      .dbg_state          (dbg)
    );

    function automatic string tg(input string s);
      return $sformatf("c%0d_w%0dk%0de%0d_%s", g, GW, GK, GE, s);
    endfunction

    // Product as plain modulo-2^(2W) multiplication of the extended operands.
    function automatic logic [2*GW-1:0] model_product(input logic [GW-1:0] x, input logic [GW-1:0] y,
                                                      input logic s);
      logic [2*GW-1:0] xe, ye;
      xe = s ? {{GW{x[GW-1]}}, x} : {{GW{1'b0}}, x};
      ye = s ? {{GW{y[GW-1]}}, y} : {{GW{1'b0}}, y};
      return xe * ye;
    endfunction

    function automatic int model_cycles(input logic [GW-1:0] y, input logic s);
      longint mag;
      int     bits;
      if (GE == 0) return GW / GK;
      mag  = (s && y[GW-1]) ? ((longint'(1) << GW) - longint'(y)) : longint'(y);
      bits = 0;
      while (mag > 0) begin
        bits++;
        mag = mag / 2;
      end
      return (bits == 0) ? 1 : (bits + GK - 1) / GK;
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with it idle.
    task automatic run_txn(input logic [GW-1:0] ta, input logic [GW-1:0] tb_, input logic ts,
                           input int stall);
      logic [2*GW-1:0] exp_res;
      int              n_exp, e;
      exp_res = model_product(ta, tb_, ts);
      n_exp   = model_cycles(tb_, ts);
      check_val(tg("req_rdy_idle"), req_rdy, 1);
      a = ta; b = tb_; sgn = ts; req_val = 1'b1;
      @(posedge clk);
      @(negedge clk);
      // Junk operands after accept must not disturb the computation.
      a = GW'($urandom); b = GW'($urandom); sgn = 1'($urandom);
      req_val = (stall > 0);
      e = 0;
      while (!resp_val && e < n_exp + 6) begin
        @(posedge clk);
        @(negedge clk);
        e++;
      end
      check_val(tg("latency"), e, n_exp + 1);
      for (int i = 0; i < stall; i++) begin
        check_val(tg("stall_val"), resp_val, 1);
        check_val(tg("stall_res"), result, exp_res);
        check_val(tg("stall_rdy"), req_rdy, 0);
        @(posedge clk);
        @(negedge clk);
      end
      check_val(tg("result"), result, exp_res);
      resp_rdy = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_rdy = 1'b0;
      check_val(tg("resp_drop"), resp_val, 0);
      check_val(tg("bubble_rdy"), req_rdy, 1);
      req_val = 1'b0;
    endtask

    initial begin
      logic [GW-1:0] mn;
      logic [GW-1:0] ra, rb;
      int            rc;
      reset = 1'b0; a = '0; b = '0; sgn = 1'b0; req_val = 1'b0; resp_rdy = 1'b0;
      @(negedge clk);
      check_val(tg("rst_rdy"), req_rdy, 1);
      check_val(tg("rst_val"), resp_val, 0);
      check_val(tg("rst_res"), result, 0);
      reset = 1'b1;
      @(negedge clk);

      mn = '0;
      mn[GW-1] = 1'b1;
      run_txn('1, '1, 1'b0, 0);
      run_txn(GW'(-7), GW'(3), 1'b1, 0);
      run_txn(mn, GW'(1), 1'b1, 0);
      run_txn(mn, GW'(1), 1'b0, 0);
      run_txn(mn, '1, 1'b1, 0);
      run_txn(GW'(32'h12345678), '0, 1'b0, 0);
      run_txn(GW'(32'hdeadbeef), GW'(32'h1234abcd), 1'b1, 5);

      // Asynchronous reset in the middle of the CAL phase.
      a = '1; b = '1; sgn = 1'b0; req_val = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_val = 1'b0;
      rc = (GW / GK < 4) ? GW / GK : 4;
      repeat (rc - 1) begin
        @(posedge clk);
        @(negedge clk);
      end
      check_val(tg("midcal_state"), dbg, ST_CAL);
      reset = 1'b0;
      #1;
      check_val(tg("midcal_rst_rdy"), req_rdy, 1);
      check_val(tg("midcal_rst_val"), resp_val, 0);
      check_val(tg("midcal_rst_res"), result, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      run_txn(GW'(6), GW'(7), 1'b0, 0);
      check_val(tg("six_by_seven"), result, 42);

      repeat (20) begin
        ra = GW'($urandom);
        rb = GW'($urandom >> $urandom_range(0, GW));
        run_txn(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
      end
      n_done++;
    end
  end

  initial begin
    for (int i = 0; i < 80000 && n_done < NCFG; i++) @(posedge clk);
    check_val("all_configs_done", n_done, NCFG);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
